cpu6_bus_peripherals: RTL and testbench

//  Parametrised CPU6 bus slave: boot-vector ROM, a sized RAM window with a read-only mirror,
//  a buffered UART transmitter and a simulation halt register. It replaces ad-hoc bench

---
 rtl/cpu6_bus_peripherals_pkg.sv | 38 +++
 rtl/cpu6_bus_peripherals_if.sv | 12 +
 rtl/cpu6_bus_peripherals_uart_tx_serializer.sv | 92 +++++++++
 rtl/cpu6_bus_peripherals.sv | 119 +++++++++++
 tb/tb_cpu6_bus_peripherals.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu6_bus_peripherals_pkg.sv
// Shared definitions for the CPU6 bus peripheral block.
// Holds default address map, boot-vector opcode, status bit positions and TX states.
// Pure definitions; no logic, no latency.
package cpu6_bus_peripherals_pkg;

  localparam logic [15:0] DEF_RAM_BASE    = 16'h8000;
  localparam logic [15:0] DEF_MIRROR_BASE = 16'h8800;
  localparam logic [15:0] DEF_VEC0_ADDR   = 16'hF800;
  localparam logic [15:0] DEF_VEC1_ADDR   = 16'hFD00;
  localparam logic [15:0] DEF_JMP_TARGET  = 16'h8001;
  localparam logic [15:0] DEF_UART_ADDR   = 16'hF200;
  localparam logic [15:0] DEF_HALT_ADDR   = 16'hF900;

  localparam logic [7:0] JMP_OPCODE = 8'h71;

  // Bit positions inside the UART status register
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Byte idx of a 3-byte boot vector: JMP opcode followed by target high, target low
  function automatic logic [7:0] vec_byte(input logic [1:0] idx, input logic [15:0] target);
    case (idx)
      2'd0:    return JMP_OPCODE;
      2'd1:    return target[15:8];
      default: return target[7:0];
    endcase
  endfunction

endpackage

// File: rtl/cpu6_bus_peripherals_if.sv
// CPU6 bus: address, write strobe, write data and combinational read data.
// Read data is combinational from address; writes are sampled on the clock edge.
// No backpressure: the slave accepts every cycle.
interface cpu6_bus_peripherals_if;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  modport master (output address, write_en, data_in, input data_out);
  modport slave  (input address, write_en, data_in, output data_out);
endinterface

// File: rtl/cpu6_bus_peripherals_uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
// A frame is 10*CLKS_PER_BIT clocks; tx is registered and starts the cycle after a load.
// ready is high in IDLE and on the last STOP clock, so queued bytes chain with no idle gap.
module uart_tx_serializer
  import cpu6_bus_peripherals_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_byte,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign ready = (state == TX_IDLE) || ((state == TX_STOP) && (baud_cnt == BAUD_LAST));
  assign busy  = (state != TX_IDLE);

  // Frame FSM; tx is set together with the state it belongs to
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (valid) begin
            shreg    <= tx_byte;
            baud_cnt <= '0;
            state    <= TX_START;
            tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (valid) begin
              shreg <= tx_byte;
              state <= TX_START;
              tx    <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/cpu6_bus_peripherals.sv
// CPU6 bus slave: boot vectors, RAM with read-only mirror, FIFO-buffered UART TX, halt flag.
// Reads are combinational from address; writes land on the rising edge.
// Never stalls the CPU: a write to a full TX FIFO is dropped and flagged in ovf.
module cpu6_bus_peripherals
  import cpu6_bus_peripherals_pkg::*;
#(
  parameter int          RAM_AW       = 11,
  parameter logic [15:0] RAM_BASE     = DEF_RAM_BASE,
  parameter logic [15:0] MIRROR_BASE  = DEF_MIRROR_BASE,
  parameter logic [15:0] VEC0_ADDR    = DEF_VEC0_ADDR,
  parameter logic [15:0] VEC1_ADDR    = DEF_VEC1_ADDR,
  parameter logic [15:0] JMP_TARGET   = DEF_JMP_TARGET,
  parameter logic [15:0] UART_ADDR    = DEF_UART_ADDR,
  parameter logic [15:0] HALT_ADDR    = DEF_HALT_ADDR,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cpu6_bus_peripherals_if.slave bus,
  output logic                  uart_tx,
  output logic                  halted
);
  // One extra pointer bit distinguishes full from empty
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] STAT_ADDR = UART_ADDR + 16'd1;

  logic [7:0]    ram [2**RAM_AW];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, level;
  logic          full, empty, push_req, push, pop, ovf_set, ovf_clr, ovf;
  logic          ser_ready, ser_busy;
  logic          in_ram, in_mirror;
  logic [15:0]   v0_off, v1_off;
  logic [7:0]    status, rd_data;

  assign in_ram    = (bus.address[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
  assign in_mirror = (bus.address[15:RAM_AW] == MIRROR_BASE[15:RAM_AW]);
  assign v0_off    = bus.address - VEC0_ADDR;
  assign v1_off    = bus.address - VEC1_ADDR;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == PW'(FIFO_DEPTH));
  assign empty    = (wr_ptr == rd_ptr);
  assign pop      = !empty && ser_ready;
  assign push_req = bus.write_en && (bus.address == UART_ADDR);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  // The clear bit in a status write sits at the ovf flag's own position
  assign ovf_clr  = bus.write_en && (bus.address == STAT_ADDR) && bus.data_in[STAT_OVF];

  // Assemble the status byte from the FIFO and serializer flags
  always_comb begin
    status             = 8'h00;
    status[STAT_BUSY]  = ser_busy;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_OVF]   = ovf;
  end

  // Read decode, vectors first, then status, then RAM/mirror; everything else reads 0
  always_comb begin
    rd_data = 8'h00;
    if (v0_off < 16'd3)
      rd_data = vec_byte(v0_off[1:0], JMP_TARGET);
    else if (v1_off < 16'd3)
      rd_data = vec_byte(v1_off[1:0], JMP_TARGET);
    else if (bus.address == STAT_ADDR)
      rd_data = status;
    else if (in_ram || in_mirror)
      rd_data = ram[bus.address[RAM_AW-1:0]];
  end

  assign bus.data_out = rd_data;

  // RAM storage; contents survive reset, only the read/write window is writable
  always_ff @(posedge clock) begin
    if (bus.write_en && in_ram)
      ram[bus.address[RAM_AW-1:0]] <= bus.data_in;
  end

  // TX FIFO storage
  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr[PW-2:0]] <= bus.data_in;
  end

  // FIFO pointers, sticky overflow and sticky halt flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (bus.write_en && (bus.address == HALT_ADDR) && (bus.data_in == 8'h01))
        halted <= 1'b1;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock   (clock),
    .reset_n (reset_n),
    .tx_byte (fifo_mem[rd_ptr[PW-2:0]]),
    .valid   (!empty),
    .ready   (ser_ready),
    .tx      (uart_tx),
    .busy    (ser_busy)
  );
endmodule

// File: tb/tb_cpu6_bus_peripherals.sv
// Bench for cpu6_bus_peripherals: decode, RAM, UART framing, FIFO overflow, halt, reset.
// UART bytes are checked by a line monitor against a queue of expected bytes.
// Inputs change on the falling edge; outputs are sampled on or just after it.
module tb_cpu6_bus_peripherals;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic uart_tx;
  logic halted;

  cpu6_bus_peripherals_if bus();

  cpu6_bus_peripherals dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .uart_tx (uart_tx),
    .halted  (halted)
  );

  initial forever #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] sb[$];
  int         frame_start[$];

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Line monitor: mid-bit sampling, 16 clocks per bit, aborts on reset
  initial begin : monitor
    logic       prev_tx;
    logic       active;
    int         m_cnt;
    logic [7:0] m_byte;
    logic [7:0] exp_b;
    prev_tx = 1'b1;
    active  = 1'b0;
    m_cnt   = 0;
    m_byte  = 8'h00;
    forever begin
      @(negedge clock or negedge reset_n);
      if (!reset_n) begin
        active  = 1'b0;
        prev_tx = 1'b1;
      end else begin
        if (!active) begin
          if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
            active = 1'b1;
            m_cnt  = 0;
            frame_start.push_back(cyc);
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (active) begin
          if (m_cnt == 8) begin
            n_total++;
            if (uart_tx !== 1'b0) $display("FAIL start_bit: got %b expected 0", uart_tx);
            else n_pass++;
          end else if (m_cnt > 8 && m_cnt < 152 && ((m_cnt - 8) % 16) == 0) begin
            m_byte[(m_cnt - 8) / 16 - 1] = uart_tx;
          end else if (m_cnt == 152) begin
            n_total++;
            if (uart_tx !== 1'b1) $display("FAIL stop_bit: got %b expected 1", uart_tx);
            else n_pass++;
            n_total++;
            if (sb.size() == 0) begin
              $display("FAIL uart_byte: got %h expected no frame", m_byte);
            end else begin
              exp_b = sb.pop_front();
              if (m_byte !== exp_b) $display("FAIL uart_byte: got %h expected %h", m_byte, exp_b);
              else n_pass++;
            end
            active = 1'b0;
          end
        end
        prev_tx = uart_tx;
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    bus.address  = a;
    bus.data_in  = d;
    bus.write_en = 1'b1;
  endtask

  task automatic wr_end();
    @(negedge clock);
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    bus.write_en = 1'b0;
    bus.address  = a;
    #1 d = bus.data_out;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    bus.address  = 16'h0000;
    bus.data_in  = 8'h00;
    bus.write_en = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", uart_tx);
    else n_pass++;
    n_total++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted);
    else n_pass++;
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h04) $display("FAIL reset_status: got %h expected 04", s);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] addrs [6];
    logic [7:0]  expv  [3];
    logic [7:0]  d;
    addrs = '{16'hF800, 16'hF801, 16'hF802, 16'hFD00, 16'hFD01, 16'hFD02};
    expv  = '{8'h71, 8'h80, 8'h01};
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], d);
      n_total++;
      if (d !== expv[i % 3]) $display("FAIL vector_%h: got %h expected %h", addrs[i], d, expv[i % 3]);
      else n_pass++;
    end
    rd(16'hF803, d);
    n_total++;
    if (d !== 8'h00) $display("FAIL vector_past_end: got %h expected 00", d);
    else n_pass++;
    rd(16'hF200, d);
    n_total++;
    if (d !== 8'h00) $display("FAIL uart_data_read: got %h expected 00", d);
    else n_pass++;
  endtask

  task automatic test_ram();
    logic [7:0] d;
    wr(16'h8005, 8'h5A);
    wr_end();
    rd(16'h8005, d);
    n_total++;
    if (d !== 8'h5A) $display("FAIL ram_read: got %h expected 5a", d);
    else n_pass++;
    rd(16'h8805, d);
    n_total++;
    if (d !== 8'h5A) $display("FAIL mirror_read: got %h expected 5a", d);
    else n_pass++;
    wr(16'h8805, 8'h33);
    wr_end();
    rd(16'h8005, d);
    n_total++;
    if (d !== 8'h5A) $display("FAIL mirror_write_ignored: got %h expected 5a", d);
    else n_pass++;
    wr(16'h87FF, 8'hC3);
    wr_end();
    rd(16'h8FFF, d);
    n_total++;
    if (d !== 8'hC3) $display("FAIL mirror_top: got %h expected c3", d);
    else n_pass++;
    rd(16'h9000, d);
    n_total++;
    if (d !== 8'h00) $display("FAIL unmapped_read: got %h expected 00", d);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [7:0] s;
    int busy_cnt;
    busy_cnt = 0;
    sb.push_back(8'h48);
    wr(16'hF200, 8'h48);
    wr_end();
    for (int i = 0; i < 400; i++) begin
      rd(16'hF201, s);
      if (s[0]) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    n_total++;
    if (busy_cnt != 160) $display("FAIL busy_cycles: got %0d expected 160", busy_cnt);
    else n_pass++;
    n_total++;
    if (sb.size() != 0) $display("FAIL single_frame_drained: got %0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic [7:0] b;
    int idle_cyc;
    bit done;
    frame_start.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back(b);
      wr(16'hF200, b);
    end
    wr_end();
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h03) $display("FAIL status_full: got %h expected 03", s);
    else n_pass++;
    wr(16'hF200, 8'hEE);
    wr_end();
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h0B) $display("FAIL status_ovf: got %h expected 0b", s);
    else n_pass++;
    wr(16'hF201, 8'h08);
    wr_end();
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h03) $display("FAIL ovf_clear: got %h expected 03", s);
    else n_pass++;
    done = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < 3500 && !done; i++) begin
      rd(16'hF201, s);
      if (!s[0]) begin
        done = 1'b1;
        idle_cyc = cyc;
      end
    end
    n_total++;
    if (!done) $display("FAIL b2b_timeout: got busy expected idle within 3500 cycles");
    else n_pass++;
    n_total++;
    if (frame_start.size() != 17) $display("FAIL frame_count: got %0d expected 17", frame_start.size());
    else n_pass++;
    if (frame_start.size() == 17) begin
      n_total++;
      if (frame_start[16] - frame_start[0] != 2560)
        $display("FAIL frame_spacing: got %0d expected 2560", frame_start[16] - frame_start[0]);
      else n_pass++;
      n_total++;
      if (idle_cyc - frame_start[0] != 2720)
        $display("FAIL b2b_duration: got %0d expected 2720", idle_cyc - frame_start[0]);
      else n_pass++;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL b2b_drained: got %0d expected 0", sb.size());
    else n_pass++;
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h04) $display("FAIL status_idle: got %h expected 04", s);
    else n_pass++;
  endtask

  task automatic test_halt();
    wr(16'hF900, 8'h02);
    wr_end();
    n_total++;
    if (halted !== 1'b0) $display("FAIL halt_wrong_value: got %b expected 0", halted);
    else n_pass++;
    wr(16'hF900, 8'h01);
    #1;
    n_total++;
    if (halted !== 1'b0) $display("FAIL halt_before_edge: got %b expected 0", halted);
    else n_pass++;
    wr_end();
    n_total++;
    if (halted !== 1'b1) $display("FAIL halt_set: got %b expected 1", halted);
    else n_pass++;
    wr(16'hF900, 8'h00);
    wr_end();
    n_total++;
    if (halted !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", halted);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s;
    sb.push_back(8'h00);
    wr(16'hF200, 8'h00);
    wr_end();
    repeat (60) @(negedge clock);
    #2;
    n_total++;
    if (uart_tx !== 1'b0) $display("FAIL mid_data_tx: got %b expected 0", uart_tx);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (uart_tx !== 1'b1) $display("FAIL async_reset_tx: got %b expected 1", uart_tx);
    else n_pass++;
    sb.delete();
    n_total++;
    if (halted !== 1'b0) $display("FAIL reset_clears_halt: got %b expected 0", halted);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    rd(16'hF201, s);
    n_total++;
    if (s !== 8'h04) $display("FAIL status_after_reset: got %h expected 04", s);
    else n_pass++;
    rd(16'h8005, s);
    n_total++;
    if (s !== 8'h5A) $display("FAIL ram_preserved: got %h expected 5a", s);
    else n_pass++;
    repeat (20) @(negedge clock);
    n_total++;
    if (uart_tx !== 1'b1) $display("FAIL frame_abandoned: got %b expected 1", uart_tx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ram();
    test_single_frame();
    test_back_to_back();
    test_halt();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
